muldiv_unit: RTL and testbench

Multi-cycle RV32M multiply/divide unit. It replaces the combinational multiply/divide path in the execute-stage ALU. The block is parametrised in operand width and computes all eight M-extension operations with correct signed semantics and RISC-V divide-by-zero/overflow results. It sits beside the ALU in execute and stalls the pipeline through a valid/ready handshake.

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_unit.sv | 174 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and operand-signedness helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } muldiv_state_e;

    function automatic logic is_signed_a(input muldiv_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(input muldiv_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, with sign fix-up and RISC-V special-case results.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int CntWidth  = $clog2(DataWidth) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           op,
    input  logic [DataWidth-1:0] operand_A,
    input  logic [DataWidth-1:0] operand_B,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DataWidth-1:0] result,
    output logic                 busy
);

    localparam int W = DataWidth;
    localparam logic [W-1:0] MinNeg = {1'b1, {(W-1){1'b0}}};

    function automatic logic [W-1:0] neg_w(input logic [W-1:0] x);
        return -x;
    endfunction

    function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] x);
        return -x;
    endfunction

    muldiv_state_e       state;
    muldiv_op_e          op_q;
    logic                neg_q;
    logic [CntWidth-1:0] cnt;
    logic [2*W-1:0]      prod;
    logic [W-1:0]        quo;
    logic [W-1:0]        rem;
    logic [W-1:0]        b_mag;

    // Accept-time decode: magnitudes, negate flag and divide special cases
    muldiv_op_e          op_in;
    logic signed [W-1:0] a_s;
    logic signed [W-1:0] b_s;
    logic                sa;
    logic                sb;
    logic [W-1:0]        a_abs;
    logic [W-1:0]        b_abs;
    logic                neg_in;
    logic                div_op;
    logic                b_zero;
    logic                ovf;
    logic [W-1:0]        special_res;

    always_comb begin
        op_in       = muldiv_op_e'(op);
        a_s         = operand_A;
        b_s         = operand_B;
        sa          = is_signed_a(op_in) && (a_s < 0);
        sb          = is_signed_b(op_in) && (b_s < 0);
        a_abs       = sa ? neg_w(operand_A) : operand_A;
        b_abs       = sb ? neg_w(operand_B) : operand_B;
        neg_in      = (op_in == OP_REM) ? sa : (sa ^ sb);
        div_op      = op_in[2];
        b_zero      = (operand_B == '0);
        ovf         = (op_in inside {OP_DIV, OP_REM}) && (operand_A == MinNeg) && (b_s == -1);
        special_res = '0;
        if (b_zero)
            special_res = op_in[1] ? operand_A : '1;
        else if (ovf)
            special_res = op_in[1] ? '0 : operand_A;
    end

    // Shared iteration datapath and final sign/word selection
    logic [W:0]     mul_sum;
    logic [2*W-1:0] prod_nxt;
    logic [2*W-1:0] prod_fin;
    logic [W:0]     div_shift;
    logic [W:0]     div_trial;
    logic           div_ok;
    logic [W-1:0]   rem_nxt;
    logic [W-1:0]   quo_nxt;
    logic [W-1:0]   mul_res;
    logic [W-1:0]   div_res;

    always_comb begin
        mul_sum   = {1'b0, prod[2*W-1:W]} + {1'b0, (prod[0] ? b_mag : '0)};
        prod_nxt  = {mul_sum, prod[W-1:1]};
        prod_fin  = neg_q ? neg_2w(prod_nxt) : prod_nxt;
        mul_res   = (op_q == OP_MUL) ? prod_fin[W-1:0] : prod_fin[2*W-1:W];
        div_shift = {rem, quo[W-1]};
        div_trial = div_shift - {1'b0, b_mag};
        div_ok    = !div_trial[W];
        rem_nxt   = div_ok ? div_trial[W-1:0] : div_shift[W-1:0];
        quo_nxt   = {quo[W-2:0], div_ok};
        if (op_q[1])
            div_res = neg_q ? neg_w(rem_nxt) : rem_nxt;
        else
            div_res = neg_q ? neg_w(quo_nxt) : quo_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_q      <= OP_MUL;
            neg_q     <= 1'b0;
            cnt       <= '0;
            prod      <= '0;
            quo       <= '0;
            rem       <= '0;
            b_mag     <= '0;
            result    <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q  <= op_in;
                        neg_q <= neg_in;
                        cnt   <= CntWidth'(DataWidth);
                        b_mag <= b_abs;
                        if (div_op && (b_zero || ovf)) begin
                            result    <= special_res;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end else if (div_op) begin
                            quo   <= a_abs;
                            rem   <= '0;
                            state <= S_DIV;
                        end else begin
                            prod  <= {{W{1'b0}}, a_abs};
                            state <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    prod <= prod_nxt;
                    cnt  <= cnt - CntWidth'(1);
                    if (cnt == CntWidth'(1)) begin
                        result    <= mul_res;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DIV: begin
                    quo <= quo_nxt;
                    rem <= rem_nxt;
                    cnt <= cnt - CntWidth'(1);
                    if (cnt == CntWidth'(1)) begin
                        result    <= div_res;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic vectors, special cases, handshake, flush and reset.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] operand_A;
    logic [31:0] operand_B;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int tests = 0;
    int fails = 0;

    muldiv_unit #(.DataWidth(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .operand_A (operand_A),
        .operand_B (operand_B),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid  = 1'b1;
        op        = o;
        operand_A = a;
        operand_B = b;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        operand_A = $urandom;
        operand_B = $urandom;
    endtask

    // Latency counts the accept edge as cycle 1
    task automatic wait_valid(output int n, output logic rdy_seen);
        n = 1;
        rdy_seen = 1'b0;
        while (!out_valid && n < 200) begin
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int   n;
        logic rs;
        issue(o, a, b);
        wait_valid(n, rs);
        chk({tag, "_res"}, result, exp);
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        consume();
    endtask

    initial begin
        int          n;
        logic        rs;
        logic [31:0] held;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 3'd0;
        operand_A = '0;
        operand_B = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // MUL with latency and in_ready held low while busy
        issue(3'd0, 32'd7, 32'hFFFF_FFFD);
        chk("mul_busy", 32'(busy), 32'd1);
        wait_valid(n, rs);
        chk("mul_res", result, 32'hFFFF_FFEB);
        chk("mul_lat", 32'(n), 32'd33);
        chk("mul_in_ready_low", 32'(rs), 32'd0);
        consume();

        run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        run_op("divu",   3'd5, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 33);
        run_op("remu",   3'd7, 32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 33);
        run_op("mul_small", 3'd0, 32'd12345, 32'd678,        32'd8369910,   33);

        run_op("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        run_op("divu_z",   3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        run_op("rem_z",    3'd6, 32'd5,         32'd0,         32'h0000_0005, 1);

        // Result held while the consumer stalls
        issue(3'd5, 32'd100, 32'd7);
        wait_valid(n, rs);
        held = result;
        chk("hold_first", held, 32'd14);
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_result", result, held);
        end
        chk("hold_in_ready_low", 32'(in_ready), 32'd0);
        consume();
        chk("hold_released", 32'(out_valid), 32'd0);
        chk("hold_in_ready", 32'(in_ready), 32'd1);

        // Flush in the middle of a divide
        issue(3'd4, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        rs = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) rs = 1'b1;
        end
        chk("flush_no_valid", 32'(rs), 32'd0);

        // A request alongside flush is dropped
        @(negedge clk);
        flush     = 1'b1;
        in_valid  = 1'b1;
        op        = 3'd0;
        operand_A = 32'd3;
        operand_B = 32'd3;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_req_dropped", 32'(busy), 32'd0);

        run_op("after_flush", 3'd0, 32'd9, 32'd11, 32'd99, 33);

        // Asynchronous reset in the middle of a multiply
        issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_result", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("after_rst", 3'd3, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003, 33);

        // in_valid while busy is ignored
        issue(3'd0, 32'd6, 32'd7);
        @(negedge clk);
        in_valid  = 1'b1;
        op        = 3'd5;
        operand_A = 32'd50;
        operand_B = 32'd5;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(n, rs);
        chk("busy_ignore_res", result, 32'd42);
        consume();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
